// File: rtl/bless_port_ctrl_pkg.sv
// Shared field widths, flit layouts and FSM encoding for the BLESS resource-port controller.
package bless_port_ctrl_pkg;

  localparam int ADDR_N    = 4;   // 16-node mesh address
  localparam int SEQ_N     = 3;   // per-source sequence number
  localparam int DATA_N    = 8;   // payload width
  localparam int AGE_N     = 4;   // age field, stamped zero on injection
  localparam int BLK_N     = 8;   // blocked-cycle counter width
  localparam int CONTROL_W = 1 + SEQ_N + 2 * ADDR_N + AGE_N;
  localparam int DATA_W    = DATA_N;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_OFFER = 2'd1,
    PC_STALL = 2'd2
  } pc_state_e;

  // Router control word, MSB first: {valid, seq, src, dest, age}
  typedef struct packed {
    logic              valid;
    logic [SEQ_N-1:0]  seq;
    logic [ADDR_N-1:0] src;
    logic [ADDR_N-1:0] dest;
    logic [AGE_N-1:0]  age;
  } ctrl_t;

  typedef struct packed {
    logic [ADDR_N-1:0] dest;
    logic [DATA_N-1:0] data;
  } inj_ent_t;

  typedef struct packed {
    logic [ADDR_N-1:0] src;
    logic [SEQ_N-1:0]  seq;
    logic [DATA_N-1:0] data;
  } ej_ent_t;

  // Saturating increment so a very long stall cannot wrap starve back off
  function automatic logic [BLK_N-1:0] blk_sat_inc(input logic [BLK_N-1:0] b);
    return (&b) ? b : b + BLK_N'(1);
  endfunction

endpackage

// File: rtl/bless_flit_fifo.sv
// Small synchronous flit FIFO; push and pop may coincide, including at full.
module bless_flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // Popping frees a slot in the same cycle, so a push at full is fine if a pop accompanies it
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array: contents need no reset, count/pointers decide what is live
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bless_port_ctrl.sv
// Resource-port controller: queues core flits, stamps seq/src/age, offers them to the
// router's resource input, and buffers flits ejected at this node for the core.
module bless_port_ctrl
  import bless_port_ctrl_pkg::*;
#(
  parameter int NODE_ID    = 0,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [ADDR_N-1:0]    inj_dest,
  input  logic [DATA_N-1:0]    inj_data,
  output logic [CONTROL_W-1:0] rp_ci,
  output logic [DATA_W-1:0]    rp_di,
  input  logic                 rp_r,
  input  logic [CONTROL_W-1:0] rp_co,
  input  logic [DATA_W-1:0]    rp_do,
  output logic                 ej_valid,
  input  logic                 ej_ready,
  output logic [ADDR_N-1:0]    ej_src,
  output logic [SEQ_N-1:0]     ej_seq,
  output logic [DATA_N-1:0]    ej_data,
  output logic                 starve,
  output logic                 err_ovf,
  output logic                 err_misroute,
  input  logic                 clr_err
);

  localparam logic [ADDR_N-1:0] NODE_A = ADDR_N'(NODE_ID);

  pc_state_e         state, state_nx;
  ctrl_t             ci_q, ci_nx;
  logic [DATA_W-1:0] di_q, di_nx;
  logic [SEQ_N-1:0]  seq_q, seq_nx;
  logic [BLK_N-1:0]  blk_q, blk_nx;

  inj_ent_t inj_in, inj_head;
  logic     inj_push, inj_pop, inj_full, inj_empty;

  ej_ent_t  ej_in, ej_head;
  ctrl_t    rx;
  logic     ej_push, ej_pop, ej_full, ej_empty;
  logic     set_ovf, set_mis;

  // ---------------- injection side ----------------
  assign inj_ready = ~inj_full;
  assign inj_push  = inj_valid & ~inj_full;
  assign inj_in    = '{dest: inj_dest, data: inj_data};

  bless_flit_fifo #(.WIDTH($bits(inj_ent_t)), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inj_push),
    .din   (inj_in),
    .pop   (inj_pop),
    .dout  (inj_head),
    .full  (inj_full),
    .empty (inj_empty)
  );

  // Next-state/offer logic: the offered flit is frozen until rp_r, and the next head is
  // loaded on the accepting edge so a free router gets one flit per cycle
  always_comb begin
    state_nx = state;
    ci_nx    = ci_q;
    di_nx    = di_q;
    seq_nx   = seq_q;
    blk_nx   = blk_q;
    inj_pop  = 1'b0;
    case (state)
      PC_IDLE: begin
        if (!inj_empty) begin
          inj_pop  = 1'b1;
          ci_nx    = '{valid: 1'b1, seq: seq_q, src: NODE_A, dest: inj_head.dest, age: '0};
          di_nx    = inj_head.data;
          state_nx = PC_OFFER;
        end
      end
      PC_OFFER, PC_STALL: begin
        if (rp_r) begin
          seq_nx = seq_q + SEQ_N'(1);
          blk_nx = '0;
          if (!inj_empty) begin
            inj_pop  = 1'b1;
            ci_nx    = '{valid: 1'b1, seq: seq_nx, src: NODE_A, dest: inj_head.dest, age: '0};
            di_nx    = inj_head.data;
            state_nx = PC_OFFER;
          end else begin
            ci_nx.valid = 1'b0;
            state_nx    = PC_IDLE;
          end
        end else begin
          state_nx = PC_STALL;
          blk_nx   = (state == PC_OFFER) ? BLK_N'(1) : blk_sat_inc(blk_q);
        end
      end
      default: state_nx = PC_IDLE;
    endcase
  end

  // FSM, offered flit, sequence and blocked-cycle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PC_IDLE;
      ci_q  <= '0;
      di_q  <= '0;
      seq_q <= '0;
      blk_q <= '0;
    end else begin
      state <= state_nx;
      ci_q  <= ci_nx;
      di_q  <= di_nx;
      seq_q <= seq_nx;
      blk_q <= blk_nx;
    end
  end

  assign rp_ci  = ci_q;
  assign rp_di  = di_q;
  assign starve = (blk_q >= BLK_N'(STARVE_LIM));

  // ---------------- ejection side ----------------
  assign rx       = ctrl_t'(rp_co);
  assign ej_valid = ~ej_empty;
  assign ej_pop   = ej_valid & ej_ready;
  assign ej_in    = '{src: rx.src, seq: rx.seq, data: rp_do};

  // Ejection filter: the router is never stalled, so anything unplaceable is dropped and flagged
  always_comb begin
    ej_push = 1'b0;
    set_ovf = 1'b0;
    set_mis = 1'b0;
    if (rx.valid) begin
      if (rx.dest != NODE_A)      set_mis = 1'b1;
      else if (ej_full && !ej_pop) set_ovf = 1'b1;
      else                         ej_push = 1'b1;
    end
  end

  bless_flit_fifo #(.WIDTH($bits(ej_ent_t)), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ej_push),
    .din   (ej_in),
    .pop   (ej_pop),
    .dout  (ej_head),
    .full  (ej_full),
    .empty (ej_empty)
  );

  assign ej_src  = ej_head.src;
  assign ej_seq  = ej_head.seq;
  assign ej_data = ej_head.data;

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf      <= 1'b0;
      err_misroute <= 1'b0;
    end else begin
      err_ovf      <= set_ovf | (err_ovf & ~clr_err);
      err_misroute <= set_mis | (err_misroute & ~clr_err);
    end
  end

endmodule

// File: tb/tb_bless_port_ctrl.sv
// Randomized bench for bless_port_ctrl against a transaction-level queue model.
module tb_bless_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inj_valid;
  logic        inj_ready;
  logic [3:0]  inj_dest;
  logic [7:0]  inj_data;
  logic [15:0] rp_ci;
  logic [7:0]  rp_di;
  logic        rp_r;
  logic [15:0] rp_co;
  logic [7:0]  rp_do;
  logic        ej_valid;
  logic        ej_ready;
  logic [3:0]  ej_src;
  logic [2:0]  ej_seq;
  logic [7:0]  ej_data;
  logic        starve;
  logic        err_ovf;
  logic        err_misroute;
  logic        clr_err;

  bless_port_ctrl #(.NODE_ID(5), .INJ_DEPTH(4), .EJ_DEPTH(2), .STARVE_LIM(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inj_valid    (inj_valid),
    .inj_ready    (inj_ready),
    .inj_dest     (inj_dest),
    .inj_data     (inj_data),
    .rp_ci        (rp_ci),
    .rp_di        (rp_di),
    .rp_r         (rp_r),
    .rp_co        (rp_co),
    .rp_do        (rp_do),
    .ej_valid     (ej_valid),
    .ej_ready     (ej_ready),
    .ej_src       (ej_src),
    .ej_seq       (ej_seq),
    .ej_data      (ej_data),
    .starve       (starve),
    .err_ovf      (err_ovf),
    .err_misroute (err_misroute),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: flits pushed but not yet accepted (head is the one on offer when m_valid)
  logic [3:0] q_dest[$];
  logic [7:0] q_data[$];
  bit         m_valid;
  int         m_seq, m_blk;
  // Model: ejection buffer of capacity 2
  logic [3:0] e_src[$];
  logic [2:0] e_seq[$];
  logic [7:0] e_data[$];
  bit         m_ovf, m_mis;

  function automatic bit m_ready();
    return (q_dest.size() - int'(m_valid)) < 4;
  endfunction

  task automatic model_reset();
    q_dest.delete(); q_data.delete();
    e_src.delete(); e_seq.delete(); e_data.delete();
    m_valid = 0; m_seq = 0; m_blk = 0; m_ovf = 0; m_mis = 0;
  endtask

  task automatic check_all();
    logic [2:0] s;
    s = m_seq[2:0];
    chk("inj_ready", inj_ready, m_ready());
    chk("ci_valid", rp_ci[15], m_valid);
    if (m_valid) begin
      chk("rp_ci", rp_ci, {1'b1, s, 4'd5, q_dest[0], 4'd0});
      chk("rp_di", rp_di, q_data[0]);
    end
    chk("starve", starve, m_blk >= 8);
    chk("ej_valid", ej_valid, e_src.size() > 0);
    if (e_src.size() > 0) begin
      chk("ej_src", ej_src, e_src[0]);
      chk("ej_seq", ej_seq, e_seq[0]);
      chk("ej_data", ej_data, e_data[0]);
    end
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_misroute", err_misroute, m_mis);
  endtask

  // Advance the model across the coming clock edge using the inputs just driven
  task automatic model_step();
    bit push, epop, efull, so, sm;
    push = inj_valid && m_ready();
    if (m_valid && rp_r) begin
      void'(q_dest.pop_front()); void'(q_data.pop_front());
      m_seq = (m_seq + 1) % 8;
      m_blk = 0;
    end else if (m_valid && m_blk < 255) begin
      m_blk++;
    end
    m_valid = q_dest.size() > 0;   // a flit pushed this edge shows up one edge later
    if (push) begin q_dest.push_back(inj_dest); q_data.push_back(inj_data); end

    epop  = (e_src.size() > 0) && ej_ready;
    efull = e_src.size() == 2;
    so = 0; sm = 0;
    if (epop) begin void'(e_src.pop_front()); void'(e_seq.pop_front()); void'(e_data.pop_front()); end
    if (rp_co[15]) begin
      if (rp_co[7:4] != 4'd5)  sm = 1;
      else if (efull && !epop) so = 1;
      else begin e_src.push_back(rp_co[11:8]); e_seq.push_back(rp_co[14:12]); e_data.push_back(rp_do); end
    end
    m_ovf = so || (m_ovf && !clr_err);
    m_mis = sm || (m_mis && !clr_err);
  endtask

  task automatic rand_cycle(input int p_rr, input int p_inj, input int p_ej, input int p_pop);
    logic [3:0] d;
    @(negedge clk);
    check_all();
    inj_valid = $urandom_range(99) < p_inj;
    inj_dest  = 4'($urandom);
    inj_data  = 8'($urandom);
    rp_r      = $urandom_range(99) < p_rr;
    d         = ($urandom_range(9) < 8) ? 4'd5 : 4'($urandom);
    rp_co     = {1'($urandom_range(99) < p_ej), 3'($urandom), 4'($urandom), d, 4'($urandom)};
    rp_do     = 8'($urandom);
    ej_ready  = $urandom_range(99) < p_pop;
    clr_err   = $urandom_range(99) < 4;
    model_step();
  endtask

  task automatic idle_inputs();
    inj_valid = 0; inj_dest = 0; inj_data = 0; rp_r = 0;
    rp_co = 0; rp_do = 0; ej_ready = 0; clr_err = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rp_ci", rp_ci, 16'h0);
    chk("rst_rp_di", rp_di, 8'h0);
    chk("rst_inj_ready", inj_ready, 1);
    chk("rst_ej_valid", ej_valid, 0);
    chk("rst_starve", starve, 0);
    chk("rst_errs", {err_ovf, err_misroute}, 2'b00);
    rst_n = 1;

    // First flit: one cycle from push to offer, stamped seq=0 src=5 age=0
    @(negedge clk);
    inj_valid = 1; inj_dest = 4'd7; inj_data = 8'hA5; rp_r = 1;
    @(negedge clk);
    inj_valid = 0;
    chk("lat_not_yet", rp_ci[15], 0);
    @(negedge clk);
    chk("first_ci", rp_ci, 16'h8570);
    chk("first_di", rp_di, 8'hA5);

    // Restart with a clean model for the random phases
    rst_n = 0; idle_inputs();
    @(negedge clk);
    rst_n = 1;
    model_reset();

    repeat (400) rand_cycle(90, 80, 50, 70);   // mostly flowing, seq wraps many times
    repeat (300) rand_cycle(40, 60, 70, 30);   // contention and ejection overflow
    repeat (30)  rand_cycle(0, 80, 30, 50);    // long stall: fills FIFO, raises starve
    repeat (300) rand_cycle(60, 70, 50, 60);

    // Reset mid-stall: offer and queues vanish at once, seq restarts at 0
    repeat (20) rand_cycle(0, 90, 0, 0);
    @(negedge clk);
    check_all();
    rst_n = 0;
    idle_inputs();
    #1;
    chk("mid_rst_valid", rp_ci[15], 0);
    chk("mid_rst_ready", inj_ready, 1);
    chk("mid_rst_starve", starve, 0);
    chk("mid_rst_ej", ej_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    repeat (400) rand_cycle(75, 75, 60, 60);
    @(negedge clk);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
